eth_pktgen_mc: RTL and testbench

Parametrised multi-channel Ethernet test-frame generator, successor to the fixed single-stream generator with one inter-frame-gap (IFG) parameter. Emits frames on a 64-bit AXI-Stream master toward the 10G MAC TX path in eth_top. Frame length, IFG and frame count are runtime-configurable. Frames are interleaved round-robin over NUM_CH logical channels, each with its own sequence counter. Frames carry a header that the bench and the loopback checker can verify.

---
 rtl/eth_pktgen_pkg.sv | 18 +
 rtl/eth_pktgen_beat.sv | 73 +++++++
 rtl/eth_pktgen_mc.sv | 173 +++++++++++++++++
 tb/tb_eth_pktgen_mc.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pktgen_pkg.sv
// Shared types and constants for the multi-channel Ethernet test-frame generator.
package eth_pktgen_pkg;

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_e;

  localparam int          ETH_MIN_LEN    = 60;
  localparam logic [15:0] ETHERTYPE_TEST = 16'h88B5;
  localparam int          HDR_BYTES      = 22;

  // Byte enables for the last beat; a remainder of 0 means the beat is full.
  function automatic logic [7:0] keep_from_len(input logic [2:0] rem);
    logic [7:0] k;
    k = 8'hFF;
    if (rem != 3'd0) k = 8'(9'h001 << rem) - 8'h01;
    return k;
  endfunction

endpackage

// File: rtl/eth_pktgen_beat.sv
// Forms one 64-bit beat (data, keep, last) of a test frame and registers it on load.
module eth_pktgen_beat
  import eth_pktgen_pkg::*;
#(
  parameter int          LEN_W   = 14,
  parameter int          CH_W    = 2,
  parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC = 48'h0200_0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [LEN_W-4:0] beat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [CH_W-1:0]  ch_i,
  input  logic [31:0]      seq_i,
  output logic [63:0]      tdata_o,
  output logic [7:0]       tkeep_o,
  output logic             tlast_o
);
  localparam int BW = LEN_W - 3;

  logic [63:0] data_d;
  logic [7:0]  keep_d;
  logic [BW-1:0] last_beat;
  logic        is_last;

  function automatic logic [7:0] byte_at(input logic [LEN_W-1:0] b, input logic [LEN_W-1:0] len,
                                         input logic [7:0] ch, input logic [31:0] seq);
    logic [7:0]  v;
    logic [15:0] len16;
    int          i;
    len16 = 16'(len);
    i     = int'(b[4:0]);
    v     = b[7:0];
    if (b < LEN_W'(HDR_BYTES)) begin
      if (i < 6)        v = 8'(DST_MAC >> (8 * (5 - i)));
      else if (i < 12)  v = 8'(SRC_MAC >> (8 * (11 - i))) | ((i == 11) ? ch : 8'h00);
      else if (i == 12) v = ETHERTYPE_TEST[15:8];
      else if (i == 13) v = ETHERTYPE_TEST[7:0];
      else if (i == 14) v = ch;
      else if (i == 15) v = 8'h00;
      else if (i < 20)  v = 8'(seq >> (8 * (19 - i)));
      else if (i == 20) v = len16[15:8];
      else              v = len16[7:0];
    end
    if (b >= len) v = 8'h00;
    return v;
  endfunction

  always_comb begin
    data_d = '0;
    for (int n = 0; n < 8; n++)
      data_d[8*n +: 8] = byte_at({beat_i, 3'(n)}, len_i, 8'(ch_i), seq_i);
  end

  assign last_beat = BW'((len_i - 1'b1) >> 3);
  assign is_last   = (beat_i == last_beat);
  assign keep_d    = is_last ? keep_from_len(len_i[2:0]) : 8'hFF;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tdata_o <= '0;
      tkeep_o <= '0;
      tlast_o <= 1'b0;
    end else if (load_i) begin
      tdata_o <= data_d;
      tkeep_o <= keep_d;
      tlast_o <= is_last;
    end
  end

endmodule

// File: rtl/eth_pktgen_mc.sv
// Multi-channel Ethernet test-frame generator: round-robin channels, per-channel sequence numbers.
// state | meaning
// IDLE  | no run active; waiting for start
// FRAME | presenting the beats of the current frame
// GAP   | counting idle cycles after a frame's tlast
module eth_pktgen_mc
  import eth_pktgen_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          LEN_W   = 14,
  parameter int          IFG_W   = 28,
  parameter int          MAX_LEN = 9000,
  parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC = 48'h0200_0000_0000
) (
  input  logic             user_clk,
  input  logic             cold_reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [IFG_W-1:0] ifg_len,
  input  logic [31:0]      frame_count,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic [31:0]      frames_sent
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW   = LEN_W - 3;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [IFG_W-1:0] ifg_q, gap_cnt_q;
  logic [31:0]      cnt_q, frames_sent_q;
  logic [CH_W-1:0]  ch_q;
  logic [31:0]      seq_q [NUM_CH];
  logic [BW-1:0]    beat_q;
  logic             stop_pend_q, busy_q, tvalid_q;

  logic [LEN_W-1:0] len_clamped, ld_len;
  logic [CH_W-1:0]  ch_nxt, ld_ch;
  logic [31:0]      fs_inc, ld_seq;
  logic [BW-1:0]    ld_beat;
  logic             hs, last_hs, run_done, ld_en;

  always_comb begin
    len_clamped = frame_len;
    if (frame_len < LEN_W'(ETH_MIN_LEN))  len_clamped = LEN_W'(ETH_MIN_LEN);
    else if (frame_len > LEN_W'(MAX_LEN)) len_clamped = LEN_W'(MAX_LEN);
  end

  assign hs       = tvalid_q & m_axis_tready;
  assign last_hs  = hs & m_axis_tlast;
  assign ch_nxt   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
  assign fs_inc   = (frames_sent_q == '1) ? frames_sent_q : frames_sent_q + 32'd1;
  assign run_done = stop_pend_q | stop | ((cnt_q != '0) && (fs_inc >= cnt_q));

  // Decide which beat the output register loads next; seq for a back-to-back frame on
  // the same channel (NUM_CH=1) must already include this frame's increment.
  always_comb begin
    ld_en   = 1'b0;
    ld_beat = '0;
    ld_len  = len_q;
    ld_ch   = ch_q;
    ld_seq  = seq_q[ch_q];
    unique case (state_q)
      IDLE: if (start) begin
        ld_en  = 1'b1;
        ld_len = len_clamped;
      end
      FRAME: if (hs) begin
        if (!m_axis_tlast) begin
          ld_en   = 1'b1;
          ld_beat = beat_q + 1'b1;
        end else if ((ifg_q == '0) && !run_done) begin
          ld_en  = 1'b1;
          ld_ch  = ch_nxt;
          ld_seq = (ch_nxt == ch_q) ? seq_q[ch_q] + 32'd1 : seq_q[ch_nxt];
        end
      end
      GAP: if (!(stop | stop_pend_q) && (gap_cnt_q == IFG_W'(1))) ld_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or negedge cold_reset_n) begin
    if (!cold_reset_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      ifg_q         <= '0;
      gap_cnt_q     <= '0;
      cnt_q         <= '0;
      frames_sent_q <= '0;
      ch_q          <= '0;
      beat_q        <= '0;
      stop_pend_q   <= 1'b0;
      busy_q        <= 1'b0;
      tvalid_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
    end else begin
      if (ld_en) beat_q <= ld_beat;
      unique case (state_q)
        IDLE: if (start) begin
          state_q       <= FRAME;
          busy_q        <= 1'b1;
          tvalid_q      <= 1'b1;
          len_q         <= len_clamped;
          ifg_q         <= ifg_len;
          cnt_q         <= frame_count;
          frames_sent_q <= '0;
          stop_pend_q   <= 1'b0;
        end
        FRAME: begin
          if (stop) stop_pend_q <= 1'b1;
          if (last_hs) begin
            frames_sent_q <= fs_inc;
            seq_q[ch_q]   <= seq_q[ch_q] + 32'd1;
            ch_q          <= ch_nxt;
            if (run_done) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              tvalid_q    <= 1'b0;
              stop_pend_q <= 1'b0;
            end else if (ifg_q != '0) begin
              state_q   <= GAP;
              tvalid_q  <= 1'b0;
              gap_cnt_q <= ifg_q;
            end
          end
        end
        GAP: begin
          if (stop || stop_pend_q) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else if (gap_cnt_q == IFG_W'(1)) begin
            state_q  <= FRAME;
            tvalid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  eth_pktgen_beat #(
    .LEN_W  (LEN_W),
    .CH_W   (CH_W),
    .DST_MAC(DST_MAC),
    .SRC_MAC(SRC_MAC)
  ) u_beat (
    .clk_i  (user_clk),
    .rst_n_i(cold_reset_n),
    .load_i (ld_en),
    .beat_i (ld_beat),
    .len_i  (ld_len),
    .ch_i   (ld_ch),
    .seq_i  (ld_seq),
    .tdata_o(m_axis_tdata),
    .tkeep_o(m_axis_tkeep),
    .tlast_o(m_axis_tlast)
  );

  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_eth_pktgen_mc.sv
// Bench for eth_pktgen_mc: frame-level reference model checked every output cycle, plus directed literals.
module tb_eth_pktgen_mc;
  localparam int NUM_CH = 4;

  logic        user_clk = 1'b0;
  logic        cold_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] frame_len = '0;
  logic [27:0] ifg_len = '0;
  logic [31:0] frame_count = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        busy;
  logic [31:0] frames_sent;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] m_seq [NUM_CH];
  int          m_ptr, m_L, m_ifg, m_beat, gap_cnt, last_gap, cap_beats, first_ch, frames_obs;
  logic [31:0] m_cnt, m_sent, first_seq, cap_seq;
  bit          run_active, stop_pend, after_tlast, first_of_run, rand_ready;
  logic [7:0]  cap_keep, cap_ch;
  logic [7:0]  cap [0:9007];

  eth_pktgen_mc #(.NUM_CH(NUM_CH)) dut (
    .user_clk     (user_clk),
    .cold_reset_n (cold_reset_n),
    .start        (start),
    .stop         (stop),
    .frame_len    (frame_len),
    .ifg_len      (ifg_len),
    .frame_count  (frame_count),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  initial forever #5 user_clk = ~user_clk;

  initial forever begin
    @(posedge user_clk);
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b, input int L, input int ch, input logic [31:0] sq);
    logic [47:0] src;
    src = 48'h0200_0000_0000;
    if (b >= L) return 8'h00;
    if (b < 6) return 8'hFF;
    if (b < 11) return src[8*(11-b) +: 8];
    case (b)
      11: return src[7:0] | 8'(ch);
      12: return 8'h88;
      13: return 8'hB5;
      14: return 8'(ch);
      15: return 8'h00;
      16: return sq[31:24];
      17: return sq[23:16];
      18: return sq[15:8];
      19: return sq[7:0];
      20: return 8'(L >> 8);
      21: return 8'(L);
      default: return 8'(b);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_seq[i] = '0;
    m_ptr = 0; m_beat = 0; run_active = 0; stop_pend = 0; after_tlast = 0;
  endtask

  initial begin : compare
    logic [63:0] exp_d;
    logic [7:0]  exp_k;
    int          nb;
    forever begin
      @(negedge user_clk);
      if (cold_reset_n) begin
        if (!run_active) begin
          check("tvalid_outside_run", 64'(m_axis_tvalid), 64'd0);
        end else if (!m_axis_tvalid) begin
          if (m_beat != 0) check("tvalid_held_in_frame", 64'(m_axis_tvalid), 64'd1);
          if (after_tlast) gap_cnt++;
        end else begin
          if (after_tlast) begin
            check("ifg_idle_cycles", 64'(gap_cnt), 64'(m_ifg));
            last_gap = gap_cnt;
            after_tlast = 0;
          end
          nb = m_L - 8 * m_beat;
          for (int n = 0; n < 8; n++)
            exp_d[8*n +: 8] = exp_byte(8 * m_beat + n, m_L, m_ptr, m_seq[m_ptr]);
          exp_k = (nb >= 8) ? 8'hFF : 8'((1 << nb) - 1);
          check("tdata", m_axis_tdata, exp_d);
          check("tkeep", 64'(m_axis_tkeep), 64'(exp_k));
          check("tlast", 64'(m_axis_tlast), 64'(nb <= 8));
          check("busy_in_frame", 64'(busy), 64'd1);
          check("frames_sent_in_frame", 64'(frames_sent), 64'(m_sent));
          for (int n = 0; n < 8; n++) cap[8*m_beat+n] = m_axis_tdata[8*n +: 8];
          if (m_axis_tready) begin
            if (nb <= 8) begin
              cap_beats = m_beat + 1;
              cap_keep  = m_axis_tkeep;
              cap_ch    = cap[14];
              cap_seq   = {cap[16], cap[17], cap[18], cap[19]};
              if (first_of_run) begin
                first_ch = int'(cap[14]);
                first_seq = cap_seq;
                first_of_run = 0;
              end
              m_seq[m_ptr]++;
              m_ptr = (m_ptr + 1) % NUM_CH;
              m_sent++;
              frames_obs++;
              m_beat = 0;
              if (((m_cnt != 0) && (m_sent == m_cnt)) || stop_pend) run_active = 0;
              else begin
                after_tlast = 1;
                gap_cnt = 0;
              end
            end else begin
              m_beat++;
            end
          end
        end
      end
    end
  end

  task automatic run(input int len, input int ifg, input int cnt);
    @(posedge user_clk);
    #1;
    frame_len = 14'(len); ifg_len = 28'(ifg); frame_count = 32'(cnt); start = 1'b1;
    m_L = (len < 60) ? 60 : ((len > 9000) ? 9000 : len);
    m_ifg = ifg; m_cnt = 32'(cnt); m_sent = 0; stop_pend = 0; after_tlast = 0;
    first_of_run = 1; frames_obs = 0; m_beat = 0; run_active = 1;
    @(posedge user_clk);
    #1;
    start = 1'b0;
    check("first_beat_latency", 64'(m_axis_tvalid), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge user_clk);
      #1;
      if (!run_active && !busy) done = 1;
    end
    check("run_ends_within_budget", 64'(done), 64'd1);
    if (!done) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  task automatic wait_point(input int sent, input int beat);
    bit hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge user_clk);
      #1;
      if (m_sent == 32'(sent) && m_beat == beat && m_axis_tvalid) hit = 1;
    end
    check("wait_point_reached", 64'(hit), 64'd1);
  endtask

  initial begin : main
    int len, ifg, cnt;
    model_reset();
    rand_ready = 0;
    repeat (3) @(posedge user_clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frames_sent", 64'(frames_sent), 64'd0);
    cold_reset_n = 1'b1;

    // three 64-byte frames back-to-back
    run(64, 0, 3);
    wait_idle(300);
    check("t1_frames_sent", 64'(frames_sent), 64'd3);
    check("t1_frames_obs", 64'(frames_obs), 64'd3);
    check("t1_first_ch", 64'(first_ch), 64'd0);
    check("t1_last_ch", 64'(cap_ch), 64'd2);
    check("t1_last_seq", 64'(cap_seq), 64'd0);
    check("t1_beats", 64'(cap_beats), 64'd8);
    check("t1_last_keep", 64'(cap_keep), 64'hFF);
    check("t1_byte0", 64'(cap[0]), 64'hFF);
    check("t1_byte6", 64'(cap[6]), 64'h02);
    check("t1_byte11", 64'(cap[11]), 64'h02);
    check("t1_byte12", 64'(cap[12]), 64'h88);
    check("t1_byte13", 64'(cap[13]), 64'hB5);

    // short frame clamped to 60 with a 5-cycle gap
    run(13, 5, 2);
    wait_idle(300);
    check("t2_frames_sent", 64'(frames_sent), 64'd2);
    check("t2_first_ch", 64'(first_ch), 64'd3);
    check("t2_last_ch", 64'(cap_ch), 64'd0);
    check("t2_last_seq", 64'(cap_seq), 64'd1);
    check("t2_len_hi", 64'(cap[20]), 64'h00);
    check("t2_len_lo", 64'(cap[21]), 64'h3C);
    check("t2_beats", 64'(cap_beats), 64'd8);
    check("t2_last_keep", 64'(cap_keep), 64'h0F);
    check("t2_gap", 64'(last_gap), 64'd5);

    // backpressure
    rand_ready = 1;
    run(100, 2, 2);
    wait_idle(800);
    check("t3_frames_sent", 64'(frames_sent), 64'd2);
    check("t3_beats", 64'(cap_beats), 64'd13);
    check("t3_last_keep", 64'(cap_keep), 64'h0F);
    check("t3_byte99", 64'(cap[99]), 64'h63);
    check("t3_last_ch", 64'(cap_ch), 64'd2);

    // continuous run stopped mid frame 2
    run(64, 0, 0);
    wait_point(2, 3);
    stop = 1'b1;
    stop_pend = 1;
    @(posedge user_clk);
    #1;
    stop = 1'b0;
    wait_idle(400);
    check("t4_frames_sent", 64'(frames_sent), 64'd3);
    check("t4_last_ch", 64'(cap_ch), 64'd1);
    repeat (20) @(posedge user_clk);
    #1;
    check("t4_quiet_after_stop", 64'(m_axis_tvalid), 64'd0);

    // randomized runs
    for (int it = 0; it < 6; it++) begin
      len = (it == 0) ? 16000 : int'($urandom_range(0, 300));
      ifg = int'($urandom_range(0, 3));
      cnt = int'($urandom_range(1, 3));
      run(len, ifg, cnt);
      wait_idle(8000);
      check("rand_frames_sent", 64'(frames_sent), 64'(cnt));
      check("rand_frames_obs", 64'(frames_obs), 64'(cnt));
      if (it == 0) check("clamp_max_beats", 64'(cap_beats), 64'd1125);
    end

    // reset during beat 3 of the second frame
    run(64, 0, 0);
    wait_point(1, 3);
    cold_reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_frames_sent", 64'(frames_sent), 64'd0);
    repeat (2) @(posedge user_clk);
    #1;
    cold_reset_n = 1'b1;
    rand_ready = 0;

    // six frames then two more: interleaving continues across runs
    run(64, 0, 6);
    wait_idle(400);
    check("t5_post_reset_ch", 64'(first_ch), 64'd0);
    check("t5_post_reset_seq", 64'(first_seq), 64'd0);
    check("t5_frames_sent", 64'(frames_sent), 64'd6);
    run(64, 1, 2);
    wait_idle(200);
    check("t5_run2_first_ch", 64'(first_ch), 64'd2);
    check("t5_run2_first_seq", 64'(first_seq), 64'd1);
    check("t5_run2_last_ch", 64'(cap_ch), 64'd3);
    check("t5_run2_last_seq", 64'(cap_seq), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
